// File: rtl/pool_1_if.sv
// pool_1 stream interface: conv pixel stream in, pooled stream out.
// Carries arm/start, input pixel+qualifier, output pixel+strobe, busy/complete.
interface pool_1_if #(
  parameter int DATA_W = 8
);
  logic              pool_start;
  logic [DATA_W-1:0] d_in;
  logic              d_in_valid;
  logic [DATA_W-1:0] d_out;
  logic              pool_1_ready;
  logic              pool_1_busy;
  logic              pool_1_complete;

  modport master (
    output pool_start, d_in, d_in_valid,
    input  d_out, pool_1_ready, pool_1_busy, pool_1_complete
  );

  modport slave (
    input  pool_start, d_in, d_in_valid,
    output d_out, pool_1_ready, pool_1_busy, pool_1_complete
  );
endinterface

// File: rtl/pool_1.sv
// pool_1: 2x2/stride-2 max-pool over a raster IMG_W x IMG_H pixel stream.
// Ports: clk, rst (async active-low), bus (pool_1_if.slave: start, pixel in, pooled out, busy, complete).
module pool_1 #(
  parameter int IMG_W  = 26,
  parameter int IMG_H  = 26,
  parameter int DATA_W = 8
) (
  input logic     clk,
  input logic     rst,
  pool_1_if.slave bus
);

  localparam int PW    = IMG_W / 2;
  localparam int TOTAL = (IMG_W / 2) * (IMG_H / 2);
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H + 1);
  localparam int OW    = $clog2(TOTAL + 1);
  localparam int LW    = (PW > 1) ? $clog2(PW) : 1;
  localparam bit ODD_H = (IMG_H % 2) == 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t            state;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [OW-1:0]     out_cnt;
  logic [DATA_W-1:0] pair;
  logic [DATA_W-1:0] lbuf [PW];
  logic [DATA_W-1:0] d_out_q;
  logic              ready_q;
  logic              busy_q;
  logic              cmpl_q;

  logic [LW-1:0]     idx;
  logic [DATA_W-1:0] h;
  logic [DATA_W-1:0] m;
  logic              frame_end;
  logic              keep_r;

  // Odd height: the frame ends only once the trailing row is swallowed.
  always_comb begin
    idx       = LW'(col >> 1);
    h         = (pair > bus.d_in) ? pair : bus.d_in;
    m         = (lbuf[idx] > h) ? lbuf[idx] : h;
    keep_r    = !(ODD_H && (row == RW'(IMG_H - 1)));
    frame_end = ODD_H ? (row == RW'(IMG_H))
                      : (out_cnt == OW'(TOTAL));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      col     <= '0;
      row     <= '0;
      out_cnt <= '0;
      pair    <= '0;
      d_out_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      cmpl_q  <= 1'b0;
      for (int i = 0; i < PW; i++)
        lbuf[i] <= '0;
    end else begin
      ready_q <= 1'b0;
      cmpl_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.pool_start) begin
            state   <= BUSY;
            busy_q  <= 1'b1;
            col     <= '0;
            row     <= '0;
            out_cnt <= '0;
          end
        end
        BUSY: begin
          if (frame_end) begin
            state  <= DONE;
            busy_q <= 1'b0;
            cmpl_q <= 1'b1;
          end else if (bus.d_in_valid) begin
            if (!col[0]) begin
              pair <= bus.d_in;
            end else if (keep_r) begin
              if (!row[0]) begin
                lbuf[idx] <= h;
              end else begin
                d_out_q <= m;
                ready_q <= 1'b1;
                out_cnt <= out_cnt + 1'b1;
              end
            end
            if (col == CW'(IMG_W - 1)) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.d_out           = d_out_q;
  assign bus.pool_1_ready    = ready_q;
  assign bus.pool_1_busy     = busy_q;
  assign bus.pool_1_complete = cmpl_q;

endmodule

// File: tb/tb_pool_1.sv
// tb_pool_1: scoreboard bench for pool_1 (26x26 and 5x5 instances).
// Driver pushes expected pooled pixels; negedge monitors pop and compare.
module tb_pool_1;

  typedef struct {
    logic [7:0] v;
    int         t;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   cmp [2];
  exp_t q0[$];
  exp_t q1[$];

  pool_1_if #(.DATA_W(8)) b0();
  pool_1_if #(.DATA_W(8)) b1();

  pool_1 #(.IMG_W(26), .IMG_H(26), .DATA_W(8)) dut0 (
    .clk(clk), .rst(rst), .bus(b0)
  );
  pool_1 #(.IMG_W(5), .IMG_H(5), .DATA_W(8)) dut1 (
    .clk(clk), .rst(rst), .bus(b1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pix(input int pat, input int r, input int c);
    case (pat)
      0: pix = 8'((r + c) & 255);
      1: pix = ((r + c) % 2 == 1) ? 8'd255 : 8'd0;
      3: pix = (r == 25 && c == 25) ? 8'd255 : 8'd0;
      default: pix = 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] expv(input int pat, input int i, input int j);
    case (pat)
      0: expv = 8'(2 * i + 2 * j + 2);
      1: expv = 8'd255;
      3: expv = (i == 12 && j == 12) ? 8'd255 : 8'd0;
      default: expv = 8'd0;
    endcase
  endfunction

  task automatic mon(input int k, input logic rdy, input logic [7:0] d,
                     input logic cpl, input logic busy);
    exp_t e;
    int   n;
    n = (k == 0) ? q0.size() : q1.size();
    if (rdy) begin
      checks++;
      if (n == 0) begin
        failures++;
        $display("FAIL out%0d_extra got=%0d at cyc %0d want=none", k, d, cyc);
      end else begin
        if (k == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        if (d !== e.v || cyc != e.t) begin
          failures++;
          $display("FAIL out%0d got=%0d@%0d want=%0d@%0d", k, d, cyc, e.v, e.t);
        end
      end
    end
    if (cpl) begin
      checks++;
      if (cyc != cmp[k] || busy !== 1'b0 || n != 0) begin
        failures++;
        $display("FAIL complete%0d got cyc=%0d busy=%0b left=%0d want cyc=%0d busy=0 left=0",
                 k, cyc, busy, n, cmp[k]);
      end
      cmp[k] = -1;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      mon(0, b0.pool_1_ready, b0.d_out, b0.pool_1_complete, b0.pool_1_busy);
      mon(1, b1.pool_1_ready, b1.d_out, b1.pool_1_complete, b1.pool_1_busy);
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic start0();
    b0.pool_start = 1'b1;
    @(posedge clk); #1;
    b0.pool_start = 1'b0;
    chk("busy0_after_start", int'(b0.pool_1_busy), 1);
  endtask

  // Drives one 26x26 frame (or its first 'limit' pixels) into dut0.
  task automatic frame0(input int pat, input int limit, input bit bub,
                        input bit st_mid, input bit st_last);
    int   idx;
    int   lt;
    exp_t e;
    lt = 0;
    for (int r = 0; r < 26; r++) begin
      for (int c = 0; c < 26; c++) begin
        idx = r * 26 + c;
        if (idx < limit) begin
          if (bub) begin
            while ($urandom % 2 == 0) begin
              b0.d_in_valid = 1'b0;
              b0.d_in = 8'hA5;
              @(posedge clk); #1;
            end
          end
          b0.d_in_valid = 1'b1;
          b0.d_in = pix(pat, r, c);
          b0.pool_start = (st_mid && idx == 300) || (st_last && idx == 675);
          lt = cyc + 1;
          if (r % 2 == 1 && c % 2 == 1) begin
            e.v = expv(pat, r / 2, c / 2);
            e.t = lt;
            q0.push_back(e);
          end
          @(posedge clk); #1;
          b0.pool_start = 1'b0;
        end
      end
    end
    b0.d_in_valid = 1'b0;
    if (limit >= 676) cmp[0] = lt + 1;
  endtask

  task automatic wait_done(input int k);
    for (int i = 0; i < 12 && cmp[k] != -1; i++) @(negedge clk);
    @(posedge clk); #1;
    chk("complete_seen", cmp[k], -1);
    cmp[k] = -1;
    @(posedge clk); #1;
    chk("busy_after_done", (k == 0) ? int'(b0.pool_1_busy) : int'(b1.pool_1_busy), 0);
  endtask

  initial begin
    logic [7:0] t6 [4];
    exp_t       e;
    int         lt;
    t6[0] = 8'd6; t6[1] = 8'd8; t6[2] = 8'd16; t6[3] = 8'd18;
    cmp[0] = -1;
    cmp[1] = -1;
    rst = 1'b0;
    b0.pool_start = 1'b0; b0.d_in = '0; b0.d_in_valid = 1'b0;
    b1.pool_start = 1'b0; b1.d_in = '0; b1.d_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", int'(b0.d_out), 0);
    chk("rst_ready", int'(b0.pool_1_ready), 0);
    chk("rst_busy", int'(b0.pool_1_busy), 0);
    chk("rst_complete", int'(b0.pool_1_complete), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // ramp, continuous; pool_start coincides with the last window pixel
    start0();
    frame0(0, 676, 1'b0, 1'b0, 1'b1);
    wait_done(0);

    // ramp with random bubbles
    start0();
    frame0(0, 676, 1'b1, 1'b0, 1'b0);
    wait_done(0);

    // checkerboard, all-zero, single hot pixel
    for (int p = 1; p <= 3; p++) begin
      start0();
      frame0(p, 676, 1'b0, 1'b0, 1'b0);
      wait_done(0);
    end

    // pixels while idle must not disturb the next frame; start mid-frame ignored
    for (int i = 0; i < 5; i++) begin
      b0.d_in_valid = 1'b1;
      b0.d_in = 8'd255;
      @(posedge clk); #1;
    end
    b0.d_in_valid = 1'b0;
    chk("idle_valid_busy", int'(b0.pool_1_busy), 0);
    start0();
    frame0(0, 676, 1'b0, 1'b1, 1'b0);
    wait_done(0);

    // reset after 100 pixels, then a clean frame
    start0();
    frame0(0, 100, 1'b0, 1'b0, 1'b0);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst_dout", int'(b0.d_out), 0);
    chk("midrst_ready", int'(b0.pool_1_ready), 0);
    chk("midrst_busy", int'(b0.pool_1_busy), 0);
    chk("midrst_pending", q0.size(), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_restart", int'(b0.pool_1_busy), 0);
    start0();
    frame0(0, 676, 1'b0, 1'b0, 1'b0);
    wait_done(0);

    // 5x5 floor pooling on dut1
    b1.pool_start = 1'b1;
    @(posedge clk); #1;
    b1.pool_start = 1'b0;
    chk("busy1_after_start", int'(b1.pool_1_busy), 1);
    lt = 0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        b1.d_in_valid = 1'b1;
        b1.d_in = 8'(r * 5 + c);
        lt = cyc + 1;
        if (r % 2 == 1 && c % 2 == 1 && r < 4 && c < 4) begin
          e.v = t6[(r / 2) * 2 + c / 2];
          e.t = lt;
          q1.push_back(e);
        end
        @(posedge clk); #1;
      end
    end
    b1.d_in_valid = 1'b0;
    cmp[1] = lt + 1;
    wait_done(1);

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
